// File: rtl/riscv_memory.sv
`default_nettype none
// ============================================================================
// Module   : riscv_memory
// Brief    : Instruction memory (fetch port plus program-load port) and data
//            memory (registered word loads, byte/half/word stores) with
//            sticky fault capture for misaligned or out-of-range accesses.
// Revision : 1.0  initial release
// ============================================================================
module riscv_memory #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic [XLEN-1:0]       instruction,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [XLEN-1:0]       mem_data,
    input  logic                  mem_write,
    input  logic [1:0]            mem_size,
    output logic [XLEN-1:0]       mem_read,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [XLEN-1:0]       prog_data,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] fault_addr,
    input  logic                  fault_clear
);

    localparam int                    c_IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_DEPTH_A = ADDR_WIDTH'(DEPTH);

    localparam logic [1:0] c_SZ_BYTE = 2'd0;
    localparam logic [1:0] c_SZ_HALF = 2'd1;
    localparam logic [1:0] c_SZ_WORD = 2'd2;

    logic [XLEN-1:0] r_imem [DEPTH];
    logic [XLEN-1:0] r_dmem [DEPTH];

    logic [XLEN-1:0]       r_instruction;
    logic [XLEN-1:0]       r_mem_read;
    logic                  r_fault;
    logic [ADDR_WIDTH-1:0] r_fault_addr;

    // Word indices and range qualifiers for each port
    logic [c_IDX_W-1:0] w_pc_idx;
    logic [c_IDX_W-1:0] w_prog_idx;
    logic [c_IDX_W-1:0] w_d_idx;
    logic               w_pc_in;
    logic               w_prog_in;
    logic               w_d_in;

    assign w_pc_idx   = pc[c_IDX_W+1:2];
    assign w_prog_idx = prog_addr[c_IDX_W+1:2];
    assign w_d_idx    = mem_addr[c_IDX_W+1:2];
    assign w_pc_in    = (pc >> 2) < c_DEPTH_A;
    assign w_prog_in  = (prog_addr >> 2) < c_DEPTH_A;
    assign w_d_in     = (mem_addr >> 2) < c_DEPTH_A;

    // Byte offsets are meaningless on the word-only fetch and program ports
    logic w_unused;
    assign w_unused = &{1'b0, pc[1:0], prog_addr[1:0]};

    // Store legality, lane enables and lane-replicated write data
    logic            w_misaligned;
    logic            w_store_fault;
    logic            w_load_fault;
    logic            w_any_fault;
    logic            w_store_ok;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;

    always_comb begin
        w_misaligned = 1'b0;
        w_be         = 4'b0000;
        w_wdata      = mem_data;
        case (mem_size)
            c_SZ_BYTE: begin
                w_be    = 4'b0001 << mem_addr[1:0];
                w_wdata = {4{mem_data[7:0]}};
            end
            c_SZ_HALF: begin
                w_misaligned = mem_addr[0];
                w_be         = mem_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata      = {2{mem_data[15:0]}};
            end
            c_SZ_WORD: begin
                w_misaligned = (mem_addr[1:0] != 2'b00);
                w_be         = 4'b1111;
            end
            default: begin
                // Reserved size: treated like a misalignment so the store is dropped
                w_misaligned = 1'b1;
            end
        endcase
    end

    assign w_store_fault = mem_write & (w_misaligned | ~w_d_in);
    assign w_load_fault  = ~mem_write & ~w_d_in;
    assign w_any_fault   = w_store_fault | w_load_fault;
    assign w_store_ok    = mem_write & ~w_store_fault & ~rst;

    // Instruction memory array: program-load writes, dropped during reset
    always_ff @(posedge clk) begin
        if (prog_we && w_prog_in && !rst) begin
            r_imem[w_prog_idx] <= prog_data;
        end
    end

    // Data memory array: lane-masked stores, contents survive reset
    always_ff @(posedge clk) begin
        if (w_store_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_dmem[w_d_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered fetch and load read ports; load holds during a store cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instruction <= '0;
            r_mem_read    <= '0;
        end else begin
            r_instruction <= w_pc_in ? r_imem[w_pc_idx] : '0;
            if (!mem_write) begin
                r_mem_read <= w_d_in ? r_dmem[w_d_idx] : '0;
            end
        end
    end

    // Sticky fault capture; a fresh fault beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end else if (w_any_fault && (!r_fault || fault_clear)) begin
            r_fault      <= 1'b1;
            r_fault_addr <= mem_addr;
        end else if (fault_clear) begin
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end
    end

    assign instruction = r_instruction;
    assign mem_read    = r_mem_read;
    assign fault       = r_fault;
    assign fault_addr  = r_fault_addr;

endmodule
`default_nettype wire
